// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the 5-stage core hazard logic.
//   fwd_sel_t      : execute-stage operand source select
//   hazard_state_t : memory-stall sequencer states
//   REG_IDX_W      : architectural register index width
// ---------------------------------------------------------------------------
package pipeline_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    FAULT = 2'b10
  } hazard_state_t;

endpackage

// File: rtl/forwarding_unit.sv
// ---------------------------------------------------------------------------
// forwarding_unit
// Combinational operand-source select for one execute-stage operand.
// Ports:
//   rs          in  : execute-stage source register index
//   rd_m/rd_w   in  : memory/writeback destination indices
//   reg_write_m in  : memory-stage write enable
//   reg_write_w in  : writeback-stage write enable
//   sel         out : 2'b10 M-stage, 2'b01 W-stage, 2'b00 register file
// ---------------------------------------------------------------------------
module forwarding_unit
  import pipeline_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [REG_IDX_W-1:0] rd_m,
  input  logic [REG_IDX_W-1:0] rd_w,
  input  logic                 reg_write_m,
  input  logic                 reg_write_w,
  output logic [1:0]           sel
);

  logic m_hit_s;
  logic w_hit_s;

  // r0 is hardwired zero, so a write to it never forwards.
  assign m_hit_s = reg_write_m && (rd_m != 5'd0) && (rd_m == rs);
  assign w_hit_s = reg_write_w && (rd_w != 5'd0) && (rd_w == rs);

  // Youngest producer (M stage) wins over the older W stage.
  always_comb begin
    sel = FWD_RF;
    if (m_hit_s) begin
      sel = FWD_M;
    end else if (w_hit_s) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
// Forwarding selects, load-use stalls, branch flushes and a memory-wait
// sequencer (IDLE/WAIT/FAULT) with a watchdog for the F/D/E/M/W core.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   rs1_d, rs2_d               : decode sources
//   rs1_e, rs2_e, rd_e, load_e : execute sources/destination, load flag
//   pc_src_e                   : taken branch / jump in execute
//   rd_m, rd_w, reg_write_m/w  : later-stage destinations and enables
//   mem_req_m, mem_ready       : data-memory handshake
//   forward_a_e, forward_b_e   : operand source selects
//   stall_f/d/e/m, flush_d/e/w : pipeline register controls
//   mem_busy, mem_fault        : sequencer in WAIT / watchdog expired (sticky)
// Optional: define HAZARD_PERF_CNT_EN to add stall_cycles and flush_events.
// ---------------------------------------------------------------------------
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_d,
  input  logic [REG_IDX_W-1:0] rs2_d,
  input  logic [REG_IDX_W-1:0] rs1_e,
  input  logic [REG_IDX_W-1:0] rs2_e,
  input  logic [REG_IDX_W-1:0] rd_e,
  input  logic                 load_e,
  input  logic                 pc_src_e,
  input  logic [REG_IDX_W-1:0] rd_m,
  input  logic [REG_IDX_W-1:0] rd_w,
  input  logic                 reg_write_m,
  input  logic                 reg_write_w,
  input  logic                 mem_req_m,
  input  logic                 mem_ready,
  output logic [1:0]           forward_a_e,
  output logic [1:0]           forward_b_e,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 stall_m,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_w,
  output logic                 mem_busy,
  output logic                 mem_fault
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  hazard_state_t    state_r;
  hazard_state_t    state_next_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;
  logic             lw_stall_s;
  logic             mem_stall_s;
  logic             branch_flush_s;

  forwarding_unit u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .sel         (fwd_a_s)
  );

  forwarding_unit u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .sel         (fwd_b_s)
  );

  assign lw_stall_s  = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  // A fault freezes the pipe unconditionally until reset.
  assign mem_stall_s = (state_r == FAULT) ? 1'b1 : (mem_req_m && !mem_ready);

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sequencer next-state logic; the watchdog fires on the last allowed WAIT cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_stall_s) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_next_s = IDLE;
        end else if (wait_cnt_r == CNT_LAST) begin
          state_next_s = FAULT;
        end else begin
          state_next_s = WAIT;
        end
      end
      FAULT: begin
        state_next_s = FAULT;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Wait counter: restarts on every entry to WAIT so back-to-back accesses get a full budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= CNT_ZERO;
    end else if ((state_r == IDLE) && (state_next_s == WAIT)) begin
      wait_cnt_r <= CNT_ZERO;
    end else if ((state_r == WAIT) && !mem_ready) begin
      wait_cnt_r <= wait_cnt_r + CNT_ONE;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Stall/flush priority: memory freeze, then load-use bubble, then branch flush.
  always_comb begin
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_e        = 1'b0;
    stall_m        = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    flush_w        = 1'b0;
    branch_flush_s = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall_s) begin
      // Hold everything; W gets a bubble so the frozen M result is not retired twice.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (lw_stall_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (pc_src_e) begin
      flush_d        = 1'b1;
      flush_e        = 1'b1;
      branch_flush_s = 1'b1;
    end else begin
      stall_f = 1'b0;
    end
  end

  // Forward selects and status outputs, forced quiet while in reset.
  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    mem_busy    = 1'b0;
    if (rst) begin
      mem_busy = 1'b0;
    end else begin
      forward_a_e = fwd_a_s;
      forward_b_e = fwd_b_s;
      mem_busy    = (state_r == WAIT);
    end
  end

  assign mem_fault = (state_r == FAULT);

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters; free-running, wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      stall_cycles <= stall_f ? (stall_cycles + 32'd1) : stall_cycles;
      flush_events <= branch_flush_s ? (flush_events + 32'd1) : flush_events;
    end
  end
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Hazard and stall sequencer for the 5-stage pipelined core (F/D/E/M/W). It produces operand-forwarding selects for the execute stage, load-use stalls, and branch/jump flushes. It also runs a state machine that freezes the whole pipeline while the data memory has not acknowledged a memory-stage access. A watchdog traps memory accesses that never complete.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: maximum consecutive WAIT cycles before fault; legal range 1..65535.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rs1_d`, `rs2_d` in 5 each: decode-stage source register indices.
- `rs1_e`, `rs2_e`, `rd_e` in 5 each: execute-stage source and destination indices.
- `load_e` in 1: execute-stage instruction is a load (result from memory).
- `pc_src_e` in 1: branch taken or jump in execute.
- `rd_m`, `rd_w` in 5 each: memory- and writeback-stage destinations.
- `reg_write_m`, `reg_write_w` in 1 each: destination write enables.
- `mem_req_m` in 1: memory stage is issuing a load or store this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `forward_a_e`, `forward_b_e` out 2 each: 2'b00 regfile, 2'b10 M-stage ALU result, 2'b01 W-stage result.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1 each: hold the corresponding pipeline register.
- `flush_d`, `flush_e`, `flush_w` out 1 each: load a bubble into the D/E/W pipeline register.
- `mem_busy` out 1: FSM in WAIT.
- `mem_fault` out 1: sticky; watchdog expired.

## Operation
- Forwarding per operand (A uses `rs1_e`, B uses `rs2_e`):
  - Select 10 if `reg_write_m` and `rd_m`≠0 and `rd_m`==rs.
  - Otherwise select 01 if `reg_write_w` and `rd_w`≠0 and `rd_w`==rs.
  - Otherwise select 00. The M stage wins when both match.
- Load-use stall: `lw_stall` = `load_e` & `rd_e`≠0 & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
- Memory stall: `mem_stall` = (`mem_req_m` & !`mem_ready`) in IDLE or WAIT; always asserted in FAULT.
- FSM states:
  - IDLE→WAIT when `mem_stall`.
  - WAIT→IDLE on `mem_ready`.
  - WAIT→FAULT when `mem_ready` is low and the wait counter equals `MEM_TIMEOUT`−1.
  - FAULT exits only via `rst`.
- Wait counter: cleared on entry to WAIT, incremented each WAIT cycle with `mem_ready` low. Width is $clog2(`MEM_TIMEOUT`+1).
- Output priority (highest first):
  - `mem_stall` or FAULT: all four stalls = 1, `flush_w` = 1, `flush_d` = `flush_e` = 0. `pc_src_e` and `lw_stall` are ignored; they are re-evaluated once released.
  - Else `lw_stall`: `stall_f` = `stall_d` = 1, `flush_e` = 1.
  - Else `pc_src_e`: `flush_d` = `flush_e` = 1.
- `load_e` and `pc_src_e` are never both high (same E instruction); no combined case exists.
- `mem_fault` = 1 in FAULT.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and current state (same-cycle).
- FSM, counter and `mem_fault` are registered; `mem_busy` = (state==WAIT).
- An access acknowledged in its first cycle (`mem_ready`=1) causes no stall. An access acknowledged after N low cycles costs exactly N stall cycles.
- A new `mem_req_m` arriving in the cycle after WAIT→IDLE is evaluated fresh, and the counter restarts at 0.
- Reset (also mid-WAIT or in FAULT): next state IDLE, counter 0, `mem_fault` 0, perf counters 0.
- While `rst` is high: stalls 0, `flush_d`/`flush_e`/`flush_w` = 1, forwards 00, `mem_busy` 0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Adds outputs `stall_cycles` (32) and `flush_events` (32), both registered and reset to 0.
  - `stall_cycles` increments on any cycle with `stall_f` = 1.
  - `flush_events` increments on any cycle with `pc_src_e` taking effect.
  - Both wrap at 2^32.
- Macro undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- `pipeline_pkg` holds:
  - `fwd_sel_t` enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - `hazard_state_t` enum: IDLE, WAIT, FAULT.
  - The register-index width constant.
- Sub-module `forwarding_unit`: combinational, one per operand, instantiated twice.

## Test plan
- `rs1_e`=5, `rd_m`=5, `reg_write_m`=1, `rd_w`=5, `reg_write_w`=1 -> `forward_a_e`=10; with `rd_m`=0 instead -> 01.
- `load_e`=1, `rd_e`=7, `rs2_d`=7 -> `stall_f`=`stall_d`=`flush_e`=1 for one cycle; with `rd_e`=0 -> no stall.
- `pc_src_e`=1, no other hazards -> `flush_d`=`flush_e`=1, all stalls 0.
- `mem_req_m`=1, `mem_ready` low 3 cycles then high -> all stalls and `flush_w` high 3 cycles, `mem_busy` high 3 cycles starting the cycle after request, then IDLE. A concurrent `pc_src_e`=1 flushes only after release.
- `MEM_TIMEOUT`=4, `mem_ready` held low -> FAULT after 5 stall cycles, `mem_fault`=1 and persists. `rst` for 1 cycle -> IDLE, `mem_fault`=0.
- With `HAZARD_PERF_CNT_EN`: load-use stall (1 cycle), then 3-cycle memory wait, then a taken branch -> `stall_cycles`=4, `flush_events`=1.
